// File: rtl/ssd_pkg.sv
// Shared types and constants for the 7-segment digit scanner.
package ssd_pkg;

  typedef enum logic [0:0] {
    S_GUARD = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_t;

  // Wide enough for the largest supported digit count; users slice to NUM_DIGITS.
  localparam logic [7:0] ANODE_OFF = 8'hFF;
  localparam logic       DP_OFF    = 1'b1;

endpackage

// File: rtl/ssd_refresh_prescaler.sv
// Slot-timing prescaler: counts 0..REFRESH_DIV-1 and flags the last cycle of each slot.
module ssd_refresh_prescaler #(
  parameter  int REFRESH_DIV = 50000,
  localparam int CW          = $clog2(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt,
  output logic          slot_end
);

  assign slot_end = (cnt == CW'(REFRESH_DIV - 1));

  // Free-running slot counter, wraps on the last cycle of the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ssd_digit_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with frame-synchronous double buffering.
//
// state   | meaning
// S_GUARD | all anodes off while the downstream decoder settles on the new nibble
// S_DRIVE | current digit's anode driven low unless the digit is blanked
module ssd_digit_scanner
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD_CYC     = 2,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic                    Load,
  input  logic [NUM_DIGITS-1:0]   DpIn,
  input  logic                    Blank,
  output logic [3:0]              Count,
  output logic [NUM_DIGITS-1:0]   AnodeN,
  output logic                    DpN,
  output logic                    FrameDone
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]           cnt;
  logic                    slot_end;
  logic                    frame_end;
  scan_state_t             state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d, pend_val_q;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q;
  logic                    pend_valid_q;
  logic                    digit_dark;
  logic [NUM_DIGITS-1:0]   anode_d;
  logic                    frame_done_d;

  ssd_refresh_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt     (cnt),
    .slot_end(slot_end)
  );

  // A digit above 0 is a leading zero when it and every more-significant nibble are 0.
  function automatic logic lead_zero(input logic [4*NUM_DIGITS-1:0] v, input logic [IW-1:0] i);
    logic z;
    z = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(i) && v[4*k +: 4] != 4'h0) z = 1'b0;
    end
    return z && (i != '0);
  endfunction

  assign frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));

  // Next digit index and the display contents that take effect on this edge.
  always_comb begin
    idx_d      = idx_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    if (slot_end) idx_d = frame_end ? '0 : idx_q + 1'b1;
    if (frame_end && pend_valid_q) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
    end
  end

  // Scan FSM next state; with GUARD_CYC==0 the guard phase collapses away.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_GUARD: if (GUARD_CYC == 0 || int'(cnt) == GUARD_CYC - 1) state_d = S_DRIVE;
      S_DRIVE: if (slot_end) state_d = (GUARD_CYC == 0) ? S_DRIVE : S_GUARD;
      default: state_d = S_GUARD;
    endcase
  end

  // Anode and frame-pulse decode for the upcoming cycle, so all outputs come straight from flops.
  always_comb begin
    digit_dark   = Blank || ((BLANK_LEADING != 0) && lead_zero(disp_val_d, idx_d));
    anode_d      = ANODE_OFF[NUM_DIGITS-1:0];
    if (state_d == S_DRIVE && !digit_dark) anode_d[idx_d] = 1'b0;
    frame_done_d = (cnt == CW'(REFRESH_DIV - 2)) && (idx_q == IW'(NUM_DIGITS - 1));
  end

  // Scan state, digit index and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_GUARD;
      idx_q     <= '0;
      Count     <= 4'h0;
      AnodeN    <= ANODE_OFF[NUM_DIGITS-1:0];
      DpN       <= DP_OFF;
      FrameDone <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      Count     <= disp_val_d[4*idx_d +: 4];
      AnodeN    <= anode_d;
      DpN       <= ~disp_dp_d[idx_d];
      FrameDone <= frame_done_d;
    end
  end

  // Pending/display double buffer; a Load on the commit edge lands in pending for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
    end else begin
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      if (Load) begin
        pend_val_q   <= Value;
        pend_dp_q    <= DpIn;
        pend_valid_q <= 1'b1;
      end else if (frame_end) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ssd_digit_scanner.sv
// Bench for ssd_digit_scanner with a hex-to-segment decoder downstream of Count.
module tb_ssd_digit_scanner;

  localparam int N = 4;
  localparam int R = 8;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_in = '0;
  logic        blank = 1'b0;
  logic [3:0]  count;
  logic [3:0]  anode_n;
  logic        dp_n;
  logic        frame_done;
  logic [6:0]  seg;

  int total = 0;
  int bad   = 0;

  // Reference model: cycle number since reset release plus the visible and pending buffers.
  int          m_t;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp;
  bit          m_pv, m_blank;

  always #5 clk = ~clk;

  ssd_digit_scanner #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .GUARD_CYC    (G),
    .BLANK_LEADING(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Value    (value),
    .Load     (load),
    .DpIn     (dp_in),
    .Blank    (blank),
    .Count    (count),
    .AnodeN   (anode_n),
    .DpN      (dp_n),
    .FrameDone(frame_done)
  );

  // Active-low gfedcba segment decoder.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  always_comb seg = hex7(count);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_disp = '0; m_dp = '0; m_pend = '0; m_pdp = '0; m_pv = 0; m_blank = 0;
  endtask

  // Advance the model across one rising edge using the inputs presented during cycle m_t.
  task automatic model_edge();
    int phase, slot;
    phase = m_t % R;
    slot  = (m_t / R) % N;
    if (phase == R - 1 && slot == N - 1 && m_pv) begin
      m_disp = m_pend;
      m_dp   = m_pdp;
      m_pv   = 0;
    end
    if (load) begin
      m_pend = value;
      m_pdp  = dp_in;
      m_pv   = 1;
    end
    m_blank = blank;
    m_t++;
  endtask

  task automatic check_outputs();
    int phase, slot;
    logic [3:0] e_cnt, e_an;
    bit dark;
    phase = m_t % R;
    slot  = (m_t / R) % N;
    e_cnt = 4'((m_disp >> (4 * slot)) & 16'hF);
    dark  = m_blank || (slot > 0 && (m_disp >> (4 * slot)) == 16'h0);
    e_an  = 4'hF;
    if (phase >= G && !dark) e_an = 4'hF & ~(4'b0001 << slot);
    chk("anode_n", anode_n, e_an);
    chk("count", count, e_cnt);
    chk("dp_n", dp_n, !m_dp[slot]);
    chk("frame_done", frame_done, (phase == R - 1 && slot == N - 1));
    chk("seg", seg, hex7(e_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("frame_done_wait", frame_done, 1'b1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_anode_n", anode_n, 4'hF);
    chk("rst_count", count, 4'h0);
    chk("rst_dp_n", dp_n, 1'b1);
    chk("rst_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;
    check_outputs();
    run(1);
    chk("guard_hold", anode_n, 4'hF);
    run(1);
    chk("first_drive", anode_n, 4'b1110);
    run(10);

    load_val(16'h12AB, 4'b0101);
    run(70);

    load_val(16'h0005, 4'b0000);
    run(70);
    load_val(16'h0000, 4'b0001);
    run(70);

    load_val(16'h0A31, 4'b0010);
    run(3);
    load_val(16'h4567, 4'b1000);
    run(40);
    wait_frame_done();
    load_val(16'h8421, 4'b0100);
    run(70);

    blank = 1'b1;
    run(40);
    blank = 1'b0;
    run(40);

    for (int i = 0; i < R && (m_t % R) != 2; i++) step();
    load_val(16'h9999, 4'b1111);
    step();
    chk("pre_reset_lit", (anode_n != 4'hF), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_anode_n", anode_n, 4'hF);
    chk("async_rst_count", count, 4'h0);
    chk("async_rst_dp_n", dp_n, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_outputs();
    run(80);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) begin
        load  = 1'b1;
        value = 16'($urandom) >> (4 * $urandom_range(3));
        dp_in = 4'($urandom);
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(31) == 0) blank = ~blank;
      step();
    end
    load = 1'b0;
    blank = 1'b0;
    run(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
